// File: rtl/uart_frame_engine_if.sv
// uart_frame_engine_if: bus-side configuration, TX request and RX status bundle
interface uart_frame_engine_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic [DIV_WIDTH-1:0] baud_div;
  logic [1:0] parity_mode;
  logic two_stop;
  logic tx_data_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic transmitter_busy;
  logic receiver_busy;
  logic rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_error;
  logic rx_parity_error;
  logic rx_frame_error;
  modport master (
    output baud_div, parity_mode, two_stop, tx_data_valid, tx_data,
    input transmitter_busy, receiver_busy, rx_data_valid, rx_data, rx_error, rx_parity_error, rx_frame_error
  );
  modport slave (
    input baud_div, parity_mode, two_stop, tx_data_valid, tx_data,
    output transmitter_busy, receiver_busy, rx_data_valid, rx_data, rx_error, rx_parity_error, rx_frame_error
  );
endinterface

// File: rtl/uart_frame_engine.sv
// uart_frame_engine: full-duplex UART with baud tick generator, configurable parity/stop bits and split RX errors
module uart_frame_engine #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  uart_frame_engine_if.slave bus,
  output logic sck_rising_edge,
  output logic sout,
  input  logic sin
);
  localparam int TW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int HALF = OVERSAMPLE / 2;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  logic [DIV_WIDTH-1:0] div_cnt, term_q, term;
  logic tick;
  // terminal count is re-read only when a new period starts
  always_comb term = (div_cnt == '0) ? ((bus.baud_div == '0) ? '0 : bus.baud_div - 1'b1) : term_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      term_q <= '0;
      tick <= 1'b0;
    end else begin
      term_q <= term;
      div_cnt <= (div_cnt == term) ? '0 : div_cnt + 1'b1;
      tick <= div_cnt == term;
    end
  assign sck_rising_edge = tick;
  tx_state_t tx_state, tx_next;
  logic [TW-1:0] tx_tcnt;
  logic [BW-1:0] tx_bcnt;
  logic [DATA_BITS-1:0] tx_sh;
  logic tx_par, tx_par_en, tx_two, tx_bit_end;
  always_comb tx_bit_end = tick && tx_tcnt == TW'(OVERSAMPLE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx_state <= T_IDLE;
    else tx_state <= tx_next;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (bus.tx_data_valid) tx_next = T_START;
      T_START: if (tx_bit_end) tx_next = T_DATA;
      T_DATA:  if (tx_bit_end && tx_bcnt == BW'(DATA_BITS - 1)) tx_next = tx_par_en ? T_PAR : T_STOP1;
      T_PAR:   if (tx_bit_end) tx_next = T_STOP1;
      T_STOP1: if (tx_bit_end) tx_next = tx_two ? T_STOP2 : T_IDLE;
      default: if (tx_bit_end) tx_next = T_IDLE;
    endcase
  end
  always_comb begin
    bus.transmitter_busy = tx_state != T_IDLE;
    sout = tx_state == T_START ? 1'b0 : tx_state == T_DATA ? tx_sh[0] : tx_state == T_PAR ? tx_par : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_tcnt <= '0;
      tx_bcnt <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_par_en <= 1'b0;
      tx_two <= 1'b0;
    end else if (tx_state == T_IDLE) begin
      tx_tcnt <= '0;
      tx_bcnt <= '0;
      if (bus.tx_data_valid) begin
        tx_sh <= bus.tx_data;
        tx_par <= ^bus.tx_data ^ (bus.parity_mode == 2'b10);
        tx_par_en <= bus.parity_mode == 2'b01 || bus.parity_mode == 2'b10;
        tx_two <= bus.two_stop;
      end
    end else if (tick) begin
      tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
      if (tx_bit_end && tx_state == T_DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_bcnt <= tx_bcnt + 1'b1;
      end
    end
  logic [1:0] sin_sync;
  logic sin_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sin_sync <= 2'b11;
    else sin_sync <= {sin_sync[0], sin};
  assign sin_s = sin_sync[1];
  rx_state_t rx_state, rx_next;
  logic [TW-1:0] rx_cnt;
  logic [BW-1:0] rx_bcnt;
  logic [DATA_BITS-1:0] rx_sh;
  logic rx_par_en, rx_odd, rx_pbit, rx_samp, rx_perr, rx_ferr;
  // ticks remaining until the next mid-bit sample
  always_comb rx_samp = tick && rx_cnt == TW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_state <= R_IDLE;
    else rx_state <= rx_next;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (tick && !sin_s) rx_next = R_START;
      R_START: if (rx_samp) rx_next = sin_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_samp && rx_bcnt == BW'(DATA_BITS - 1)) rx_next = rx_par_en ? R_PAR : R_STOP;
      R_PAR:   if (rx_samp) rx_next = R_STOP;
      default: if (rx_samp) rx_next = R_IDLE;
    endcase
  end
  always_comb bus.receiver_busy = rx_state != R_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_cnt <= '0;
      rx_bcnt <= '0;
      rx_sh <= '0;
      rx_par_en <= 1'b0;
      rx_odd <= 1'b0;
      rx_pbit <= 1'b0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_data_valid <= 1'b0;
    end else begin
      bus.rx_data_valid <= 1'b0;
      if (rx_state == R_IDLE) begin
        rx_cnt <= TW'(HALF - 1);
        rx_bcnt <= '0;
        if (tick && !sin_s) begin
          rx_par_en <= bus.parity_mode == 2'b01 || bus.parity_mode == 2'b10;
          rx_odd <= bus.parity_mode == 2'b10;
        end
      end else if (tick) begin
        rx_cnt <= rx_samp ? TW'(OVERSAMPLE) : rx_cnt - 1'b1;
        if (rx_samp && rx_state == R_DATA) begin
          rx_sh <= {sin_s, rx_sh[DATA_BITS-1:1]};
          rx_bcnt <= rx_bcnt + 1'b1;
        end
        if (rx_samp && rx_state == R_PAR) rx_pbit <= sin_s;
        if (rx_samp && rx_state == R_STOP) begin
          bus.rx_data <= rx_sh;
          rx_perr <= rx_par_en && (rx_pbit != (^rx_sh ^ rx_odd));
          rx_ferr <= !sin_s;
          bus.rx_data_valid <= 1'b1;
        end
      end
    end
  assign bus.rx_parity_error = rx_perr;
  assign bus.rx_frame_error = rx_ferr;
  assign bus.rx_error = rx_perr | rx_ferr;
endmodule

// File: tb/tb_uart_frame_engine.sv
// tb_uart_frame_engine: scoreboard bench for 8-bit and 7-bit uart_frame_engine instances
module tb_uart_frame_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_frame_engine_if #(.DATA_BITS(8)) b8();
  uart_frame_engine_if #(.DATA_BITS(7)) b7();
  logic sck8, sout8, sin8, sin8_drv, loop;
  logic sck7, sout7, sin7;
  assign sin8 = loop ? sout8 : sin8_drv;
  uart_frame_engine #(.DATA_BITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8), .sck_rising_edge(sck8), .sout(sout8), .sin(sin8));
  uart_frame_engine #(.DATA_BITS(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(b7), .sck_rising_edge(sck7), .sout(sout7), .sin(sin7));
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] q8[$];
  logic [15:0] q7[$];
  int gap, len, cnt;
  logic [15:0] bits, f;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input logic [1:0] pm);
    logic [15:0] r;
    logic p;
    int n;
    r = '1;
    r[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      r[n] = d[i];
      p ^= d[i];
      n++;
    end
    if (pm == 2'b01 || pm == 2'b10) r[n] = p ^ (pm == 2'b10);
    return r;
  endfunction
  function automatic logic [15:0] rec(input logic [8:0] d, input logic pe, input logic fe);
    return {fe, pe, 5'b0, d};
  endfunction
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && b8.rx_data_valid) begin
      if (q8.size() == 0) check("rx8_unexpected", b8.rx_data_valid, 0);
      else begin
        e = q8.pop_front();
        check("rx8_data", b8.rx_data, e[8:0]);
        check("rx8_perr", b8.rx_parity_error, e[14]);
        check("rx8_ferr", b8.rx_frame_error, e[15]);
        check("rx8_err", b8.rx_error, e[14] | e[15]);
      end
    end
  end
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && b7.rx_data_valid) begin
      if (q7.size() == 0) check("rx7_unexpected", b7.rx_data_valid, 0);
      else begin
        e = q7.pop_front();
        check("rx7_data", b7.rx_data, e[8:0]);
        check("rx7_perr", b7.rx_parity_error, e[14]);
        check("rx7_ferr", b7.rx_frame_error, e[15]);
        check("rx7_err", b7.rx_error, e[14] | e[15]);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tx_observe(output int g, output int l, output logic [15:0] b);
    g = 0;
    l = 0;
    b = '1;
    while (!b8.transmitter_busy && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (!b8.transmitter_busy) begin
      check("tx_start_timeout", b8.transmitter_busy, 1);
      return;
    end
    while (b8.transmitter_busy && l < 4000) begin
      if (l % 64 == 32 && l / 64 < 16) b[l/64] = sout8;
      l++;
      @(negedge clk);
    end
  endtask
  task automatic align_tick;
    @(negedge clk);
    for (int i = 0; i < 100 && !sck8; i++) @(negedge clk);
  endtask
  task automatic tx_send_aligned(input logic [7:0] d);
    align_tick();
    b8.tx_data = d;
    b8.tx_data_valid = 1'b1;
    fork
      tx_observe(gap, len, bits);
      begin
        @(negedge clk);
        b8.tx_data_valid = 1'b0;
      end
    join
  endtask
  task automatic drive_sin(input bit sel, input logic [15:0] fb, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) sin7 = fb[i];
      else sin8_drv = fb[i];
      repeat (64) @(negedge clk);
    end
  endtask
  task automatic drain(input bit sel);
    for (int i = 0; i < 3000 && (sel ? q7.size() : q8.size()) != 0; i++) @(negedge clk);
    check(sel ? "rx7_drain" : "rx8_drain", sel ? q7.size() : q8.size(), 0);
  endtask
  initial begin
    logic seen;
    loop = 1'b0;
    sin8_drv = 1'b1;
    sin7 = 1'b1;
    b8.baud_div = 16'd4;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b0;
    b8.tx_data_valid = 1'b0;
    b8.tx_data = '0;
    b7.baud_div = 16'd4;
    b7.parity_mode = 2'b10;
    b7.two_stop = 1'b0;
    b7.tx_data_valid = 1'b0;
    b7.tx_data = '0;
    repeat (5) @(negedge clk);
    check("rst_sout", sout8, 1);
    check("rst_sck", sck8, 0);
    check("rst_txbusy", b8.transmitter_busy, 0);
    check("rst_rxbusy", b8.receiver_busy, 0);
    check("rst_rxvalid", b8.rx_data_valid, 0);
    check("rst_rxdata", b8.rx_data, 0);
    check("rst_err", {b8.rx_error, b8.rx_parity_error, b8.rx_frame_error}, 0);
    rst_n = 1'b1;
    align_tick();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sck8 && cnt < 20);
    check("tick_period", cnt, 4);
    b8.baud_div = 16'd0;
    repeat (10) @(negedge clk);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(sck8);
    end
    check("tick_div0", cnt, 4);
    b8.baud_div = 16'd4;
    repeat (10) @(negedge clk);
    loop = 1'b1;
    q8.push_back(rec(9'h0A5, 1'b0, 1'b0));
    tx_send_aligned(8'hA5);
    check("8n1_busy_len", len, 640);
    check("8n1_bits", bits, frame_bits(9'h0A5, 8, 2'b00));
    drain(0);
    b8.parity_mode = 2'b01;
    q8.push_back(rec(9'h007, 1'b0, 1'b0));
    tx_send_aligned(8'h07);
    check("even_busy_len", len, 704);
    check("even_bits", bits, frame_bits(9'h007, 8, 2'b01));
    check("even_par_bit", bits[9], ^8'h07);
    drain(0);
    loop = 1'b0;
    @(negedge clk);
    f = frame_bits(9'h007, 8, 2'b01);
    f[9] = ~f[9];
    q8.push_back(rec(9'h007, 1'b1, 1'b0));
    drive_sin(0, f, 11);
    sin8_drv = 1'b1;
    drain(0);
    seen = 1'b0;
    @(negedge clk);
    sin8_drv = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (i == 11) sin8_drv = 1'b1;
      if (b8.receiver_busy) seen = 1'b1;
    end
    check("fs_busy_seen", seen, 1);
    check("fs_busy_end", b8.receiver_busy, 0);
    check("fs_rx_data", b8.rx_data, 8'h07);
    q7.push_back(rec(9'h055, 1'b0, 1'b1));
    drive_sin(1, frame_bits(9'h055, 7, 2'b10), 9);
    sin7 = 1'b0;
    repeat (40) @(negedge clk);
    sin7 = 1'b1;
    repeat (160) @(negedge clk);
    q7.push_back(rec(9'h02A, 1'b0, 1'b0));
    drive_sin(1, frame_bits(9'h02A, 7, 2'b10), 10);
    drain(1);
    check("w7_err_clear", b7.rx_error, 0);
    loop = 1'b1;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b1;
    q8.push_back(rec(9'h03C, 1'b0, 1'b0));
    q8.push_back(rec(9'h0C3, 1'b0, 1'b0));
    align_tick();
    b8.tx_data = 8'h3C;
    b8.tx_data_valid = 1'b1;
    fork
      tx_observe(gap, len, bits);
      begin
        @(negedge clk);
        b8.tx_data = 8'hC3;
      end
    join
    check("2s_f1_len", len, 704);
    check("2s_f1_bits", bits, frame_bits(9'h03C, 8, 2'b00));
    fork
      tx_observe(gap, len, bits);
      begin
        for (int i = 0; i < 200 && !b8.transmitter_busy; i++) @(negedge clk);
        b8.tx_data_valid = 1'b0;
      end
    join
    check("2s_gap", gap, 1);
    check("2s_f2_len", len, 703);
    check("2s_f2_bits", bits, frame_bits(9'h0C3, 8, 2'b00));
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      cnt += int'(b8.transmitter_busy);
    end
    check("2s_no_third", cnt, 0);
    drain(0);
    b8.two_stop = 1'b0;
    align_tick();
    b8.tx_data = 8'h5A;
    b8.tx_data_valid = 1'b1;
    @(negedge clk);
    b8.tx_data_valid = 1'b0;
    repeat (352) @(negedge clk);
    f = frame_bits(9'h05A, 8, 2'b00);
    check("mid_sout_bit4", sout8, f[5]);
    check("mid_rxbusy", b8.receiver_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sout", sout8, 1);
    check("arst_txbusy", b8.transmitter_busy, 0);
    check("arst_rxbusy", b8.receiver_busy, 0);
    check("arst_rxdata", b8.rx_data, 0);
    check("arst_flags", {b8.rx_data_valid, b8.rx_error, b8.rx_parity_error, b8.rx_frame_error, sck8}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    check("post_rst_txbusy", b8.transmitter_busy, 0);
    check("post_rst_rxdata", b8.rx_data, 0);
    check("sb_empty", q8.size() + q7.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
